// File: rtl/id_ex_issue.sv
// Decode/issue register between fetch and the RV32I ALU: decodes OP, OP-IMM, LUI and AUIPC,
// selects and forwards operands, and holds the registered ALU bundle behind a valid/ready handshake.
module id_ex_issue #(
  parameter bit FwdEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        fwd_we_i,
  input  logic [4:0]  fwd_rd_i,
  input  logic [31:0] fwd_data_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [3:0]  ex_alu_op_o,
  output logic [31:0] ex_a_o,
  output logic [31:0] ex_b_o,
  output logic [4:0]  ex_rd_o,
  output logic        ex_we_o,
  output logic        ex_illegal_o
);

  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluSll  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluSlt  = 4'd8;
  localparam logic [3:0] AluSltu = 4'd9;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [6:0] F7Zero = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        alt;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign opcode     = instr_i[6:0];
  assign f3         = instr_i[14:12];
  assign f7         = instr_i[31:25];
  assign alt        = (f7 == F7Alt);
  assign imm_i      = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u      = {instr_i[31:12], 12'b0};
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  // x0 always reads zero; otherwise the result of the instruction in EX wins over the regfile.
  function automatic logic [31:0] sel_operand(input logic [4:0] addr, input logic [31:0] data);
    if (addr == 5'd0) begin
      return 32'd0;
    end else if (FwdEn && fwd_we_i && (fwd_rd_i == addr)) begin
      return fwd_data_i;
    end else begin
      return data;
    end
  endfunction

  assign rs1_val = sel_operand(rs1_addr_o, rs1_data_i);
  assign rs2_val = sel_operand(rs2_addr_o, rs2_data_i);

  // Shared funct3 map; alt selects SUB/SRA where the opcode permits it.
  function automatic logic [3:0] f3_to_op(input logic [2:0] fn3, input logic use_alt);
    case (fn3)
      3'b000:  return use_alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return use_alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_ill;

  always_comb begin
    dec_op  = AluAdd;
    dec_a   = 32'd0;
    dec_b   = 32'd0;
    dec_ill = 1'b0;
    case (opcode)
      OpcOp: begin
        dec_a   = rs1_val;
        dec_b   = rs2_val;
        dec_op  = f3_to_op(f3, alt);
        dec_ill = !((f7 == F7Zero) || (alt && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OpcOpImm: begin
        dec_a  = rs1_val;
        dec_b  = imm_i;
        dec_op = f3_to_op(f3, alt && (f3 == 3'b101));
        if (f3 == 3'b001) begin
          dec_ill = (f7 != F7Zero);
        end else if (f3 == 3'b101) begin
          dec_ill = !((f7 == F7Zero) || alt);
        end
      end
      OpcLui: begin
        dec_b = imm_u;
      end
      OpcAuipc: begin
        dec_a = pc_i;
        dec_b = imm_u;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op = AluAdd;
      dec_a  = 32'd0;
      dec_b  = 32'd0;
    end
  end

  logic        valid_q, valid_d;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  rd_q;
  logic        we_q, ill_q;
  logic        load;

  assign in_ready_o = !valid_q || ex_ready_i;
  // A flushed capture is dropped entirely, so the held bundle is left untouched.
  assign load       = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (ex_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      op_q    <= AluAdd;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rd_q    <= 5'd0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        op_q  <= dec_op;
        a_q   <= dec_a;
        b_q   <= dec_b;
        rd_q  <= instr_i[11:7];
        we_q  <= !dec_ill && (instr_i[11:7] != 5'd0);
        ill_q <= dec_ill;
      end
    end
  end

  assign ex_valid_o   = valid_q;
  assign ex_alu_op_o  = op_q;
  assign ex_a_o       = a_q;
  assign ex_b_o       = b_q;
  assign ex_rd_o      = rd_q;
  assign ex_we_o      = we_q;
  assign ex_illegal_o = ill_q;

endmodule
